// File: rtl/oq_remove_sched.sv
// rtl/oq_remove_sched.sv - round-robin packet-remove scheduler for the output queues
// Optional feature macro: OQ_REMOVE_BURST_EN (allows up to MAX_BURST packets per grant).
module oq_remove_sched #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
  parameter int MAX_BURST         = 4,
  parameter int BURST_WIDTH       = $clog2(MAX_BURST) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_OUTPUT_QUEUES-1:0] empty,
  input  logic [NUM_OUTPUT_QUEUES-1:0] dst_ready,
  input  logic [NUM_OUTPUT_QUEUES-1:0] oq_enable,
  output logic                         rd_req,
  output logic [NUM_OQ_WIDTH-1:0]      rd_oq,
  input  logic                         rd_ack,
  input  logic                         rd_done,
  output logic                         busy,
  output logic                         pkt_removed
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_SETTLE
  } state_t;

  state_t                         state;
  logic [NUM_OQ_WIDTH-1:0]        last_oq;
  logic [NUM_OUTPUT_QUEUES-1:0]   eligible;
  logic                           cur_eligible;
  logic                           any_eligible;
  logic [NUM_OQ_WIDTH-1:0]        next_oq;
  logic [NUM_OQ_WIDTH-1:0]        cand_oq;
  logic                           burst_more;

  assign eligible     = ~empty & dst_ready & oq_enable;
  assign cur_eligible = eligible[rd_oq];

`ifdef OQ_REMOVE_BURST_EN
  localparam logic [BURST_WIDTH-1:0] BURST_LAST = BURST_WIDTH'(MAX_BURST - 1);
  logic [BURST_WIDTH-1:0] burst_cnt;

  // Stay on the same queue while the grant has packets left and the queue still qualifies.
  assign burst_more = (burst_cnt < BURST_LAST) && cur_eligible;
`else
  logic unused_burst_cfg;

  assign unused_burst_cfg = (MAX_BURST > BURST_WIDTH);
  assign burst_more       = 1'b0;
`endif

  // Round-robin search: first eligible queue starting just after the last serviced one.
  always_comb begin
    any_eligible = 1'b0;
    next_oq      = '0;
    cand_oq      = '0;
    for (int k = 1; k <= NUM_OUTPUT_QUEUES; k++) begin
      cand_oq = NUM_OQ_WIDTH'((int'(last_oq) + k) % NUM_OUTPUT_QUEUES);
      if (!any_eligible && eligible[cand_oq]) begin
        any_eligible = 1'b1;
        next_oq      = cand_oq;
      end
    end
  end

  // Request/transfer/settle sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rd_req      <= 1'b0;
      rd_oq       <= '0;
      busy        <= 1'b0;
      pkt_removed <= 1'b0;
      last_oq     <= NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);
`ifdef OQ_REMOVE_BURST_EN
      burst_cnt   <= '0;
`endif
    end else begin
      pkt_removed <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_eligible) begin
            rd_oq     <= next_oq;
            rd_req    <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_REQ;
`ifdef OQ_REMOVE_BURST_EN
            burst_cnt <= '0;
`endif
          end
        end
        ST_REQ: begin
          // An ack wins over a same-cycle loss of eligibility: the datapath already owns it.
          if (rd_ack) begin
            rd_req <= 1'b0;
            if (rd_done) begin
              pkt_removed <= 1'b1;
              state       <= ST_SETTLE;
            end else begin
              state <= ST_XFER;
            end
          end else if (!cur_eligible) begin
            // Abandoned request: last_oq keeps its value so fairness is not disturbed.
            rd_req <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (rd_done) begin
            pkt_removed <= 1'b1;
            state       <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // The empty flag seen here already reflects the packet just removed.
          if (burst_more) begin
`ifdef OQ_REMOVE_BURST_EN
            burst_cnt <= burst_cnt + 1'b1;
`endif
            rd_req <= 1'b1;
            state  <= ST_REQ;
          end else begin
            last_oq <= rd_oq;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          rd_req <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oq_remove_sched.sv
// tb/tb_oq_remove_sched.sv - directed self-checking bench for oq_remove_sched
module tb_oq_remove_sched;

  localparam int NQ = 8;
`ifdef OQ_REMOVE_BURST_EN
  localparam int BURST_LIMIT = 4;
`else
  localparam int BURST_LIMIT = 1;
`endif

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] empty     = 8'hFF;
  logic [7:0] dst_ready = 8'hFF;
  logic [7:0] oq_enable = 8'hFF;
  logic       rd_ack    = 1'b0;
  logic       rd_done   = 1'b0;
  logic       rd_req;
  logic [2:0] rd_oq;
  logic       busy;
  logic       pkt_removed;

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  bit auto_resp = 1'b0;

  oq_remove_sched #(
    .NUM_OUTPUT_QUEUES(8),
    .NUM_OQ_WIDTH(3),
    .MAX_BURST(4),
    .BURST_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .empty(empty),
    .dst_ready(dst_ready),
    .oq_enable(oq_enable),
    .rd_req(rd_req),
    .rd_oq(rd_oq),
    .rd_ack(rd_ack),
    .rd_done(rd_done),
    .busy(busy),
    .pkt_removed(pkt_removed)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for request spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a grant owner, what it is waiting for, and packets done in the grant.
  int         m_owner = -1;
  int         m_stage = 0;
  int         m_count = 0;
  int         m_last  = NQ - 1;
  int         m_rd_oq = 0;
  int         m_pulse = 0;
  int         m_pick;
  logic [7:0] m_elig;

  function automatic int rr_pick(input int last, input logic [7:0] elig);
    int r = -1;
    for (int k = 1; k <= NQ; k++)
      if (r < 0 && elig[(last + k) % NQ]) r = (last + k) % NQ;
    return r;
  endfunction

  // Eligibility and round-robin choice from the rules.
  always_comb begin
    m_elig = ~empty & dst_ready & oq_enable;
    m_pick = rr_pick(m_last, m_elig);
  end

  // Model advance per clock; reset takes effect immediately.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= -1;
      m_stage <= 0;
      m_count <= 0;
      m_last  <= NQ - 1;
      m_rd_oq <= 0;
      m_pulse <= 0;
    end else begin
      m_pulse <= 0;
      if (m_owner < 0) begin
        if (m_pick >= 0) begin
          m_owner <= m_pick;
          m_rd_oq <= m_pick;
          m_stage <= 0;
          m_count <= 0;
        end
      end else if (m_stage == 0) begin
        if (rd_ack) begin
          m_stage <= rd_done ? 2 : 1;
          m_pulse <= rd_done ? 1 : 0;
        end else if (!m_elig[m_owner]) begin
          m_owner <= -1;
        end
      end else if (m_stage == 1) begin
        if (rd_done) begin
          m_stage <= 2;
          m_pulse <= 1;
        end
      end else begin
        if (m_count + 1 < BURST_LIMIT && m_elig[m_owner]) begin
          m_count <= m_count + 1;
          m_stage <= 0;
        end else begin
          m_last  <= m_owner;
          m_owner <= -1;
        end
      end
    end
  end

  // Compare DUT outputs against the model away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_req", int'(rd_req), int'(m_owner >= 0 && m_stage == 0));
      check("busy", int'(busy), int'(m_owner >= 0));
      check("pkt_removed", int'(pkt_removed), m_pulse);
      check("rd_oq", int'(rd_oq), m_rd_oq);
    end
  end

  bit prev_req = 1'b0;
  int n_pulse  = 0;
  int req_oq[$];
  int req_cyc[$];

  // Log each new request and count removal pulses.
  always @(negedge clk) begin
    if (rd_req && !prev_req) begin
      req_oq.push_back(int'(rd_oq));
      req_cyc.push_back(cyc);
    end
    prev_req <= rd_req;
    if (pkt_removed) n_pulse <= n_pulse + 1;
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
    if (auto_resp) begin
      rd_ack  = rd_req;
      rd_done = rd_req;
    end
  endtask

  task automatic do_reset();
    auto_resp = 1'b0;
    rd_ack    = 1'b0;
    rd_done   = 1'b0;
    empty     = 8'hFF;
    dst_ready = 8'hFF;
    oq_enable = 8'hFF;
    reset     = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    req_oq.delete();
    req_cyc.delete();
  endtask

  task automatic run_reqs(input string name, input int n, input int budget);
    int t = 0;
    while (req_oq.size() < n && t < budget) begin
      next_cycle();
      t++;
    end
    check(name, int'(req_oq.size() >= n), 1);
  endtask

  int base;

  initial begin
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;
    next_cycle();
    next_cycle();
    check("reset_rd_req", int'(rd_req), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pkt_removed", int'(pkt_removed), 0);
    check("reset_rd_oq", int'(rd_oq), 0);

    // Single packet from queue 0 after reset release.
    empty = 8'hFE;
    reset = 1'b1;
    next_cycle();
    check("t1_rd_req", int'(rd_req), 1);
    check("t1_rd_oq", int'(rd_oq), 0);
    rd_ack = 1'b1;
    next_cycle();
    check("t1_req_drop", int'(rd_req), 0);
    check("t1_busy_xfer", int'(busy), 1);
    rd_ack  = 1'b0;
    base    = n_pulse;
    rd_done = 1'b1;
    empty   = 8'hFF;
    next_cycle();
    check("t1_pulse", int'(pkt_removed), 1);
    rd_done = 1'b0;
    next_cycle();
    check("t1_idle", int'(busy), 0);
    check("t1_pulse_count", n_pulse - base, 1);

    // All queues full: round robin, 3-cycle spacing (or bursts of BURST_LIMIT).
    do_reset();
    empty     = 8'h00;
    auto_resp = 1'b1;
    run_reqs("t2_req_count", 9, 80);
    if (req_oq.size() >= 9)
      for (int k = 0; k < 9; k++) begin
        check($sformatf("t2_oq_%0d", k), req_oq[k], (k / BURST_LIMIT) % NQ);
        if (k > 0)
          check($sformatf("t2_gap_%0d", k), req_cyc[k] - req_cyc[k-1],
                (k % BURST_LIMIT != 0) ? 2 : 3);
      end

    // Only queue 3 holds packets and never drains.
    do_reset();
    empty     = 8'hF7;
    auto_resp = 1'b1;
    run_reqs("t3_req_count", 5, 40);
    if (req_oq.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        check($sformatf("t3_oq_%0d", k), req_oq[k], 3);
        if (k > 0)
          check($sformatf("t3_gap_%0d", k), req_cyc[k] - req_cyc[k-1],
                (k % BURST_LIMIT != 0) ? 2 : 3);
      end

    // Queue 5 disabled before ack: drop, last_oq stays at 1, next grant is queue 3.
    do_reset();
    empty = 8'hFD;
    next_cycle();
    check("t4_first_oq", int'(rd_oq), 1);
    rd_ack  = 1'b1;
    rd_done = 1'b1;
    empty   = 8'hFF;
    next_cycle();
    rd_ack  = 1'b0;
    rd_done = 1'b0;
    next_cycle();
    empty = 8'hDE;
    next_cycle();
    check("t4_req5", int'(rd_req), 1);
    check("t4_oq5", int'(rd_oq), 5);
    oq_enable = 8'hDF;
    empty     = 8'hD6;
    next_cycle();
    check("t4_drop_req", int'(rd_req), 0);
    check("t4_drop_busy", int'(busy), 0);
    next_cycle();
    check("t4_regrant_req", int'(rd_req), 1);
    check("t4_regrant_oq", int'(rd_oq), 3);

    // Reset during a transfer on queue 2, late rd_done ignored.
    do_reset();
    empty = 8'hFB;
    next_cycle();
    check("t5_oq2", int'(rd_oq), 2);
    rd_ack = 1'b1;
    next_cycle();
    rd_ack = 1'b0;
    check("t5_xfer_busy", int'(busy), 1);
    base  = n_pulse;
    reset = 1'b0;
    empty = 8'hFF;
    #1;
    check("t5_async_req", int'(rd_req), 0);
    check("t5_async_busy", int'(busy), 0);
    next_cycle();
    reset   = 1'b1;
    rd_done = 1'b1;
    next_cycle();
    rd_done = 1'b0;
    next_cycle();
    check("t5_busy_after", int'(busy), 0);
    check("t5_no_pulse", n_pulse - base, 0);

    // Queue 4 drains during SETTLE: move on to queue 6.
    do_reset();
    empty = 8'hAF;
    next_cycle();
    check("t6_oq4", int'(rd_oq), 4);
    rd_ack  = 1'b1;
    rd_done = 1'b1;
    next_cycle();
    rd_ack  = 1'b0;
    rd_done = 1'b0;
    empty   = 8'hBF;
    check("t6_pulse", int'(pkt_removed), 1);
    next_cycle();
    check("t6_idle_req", int'(rd_req), 0);
    next_cycle();
    check("t6_next_req", int'(rd_req), 1);
    check("t6_next_oq", int'(rd_oq), 6);

    // Protocol violations: ack/done in IDLE, done without ack in REQ.
    do_reset();
    base    = n_pulse;
    rd_ack  = 1'b1;
    rd_done = 1'b1;
    next_cycle();
    check("t7_idle_busy", int'(busy), 0);
    rd_ack  = 1'b0;
    rd_done = 1'b0;
    empty   = 8'hFE;
    next_cycle();
    rd_done = 1'b1;
    next_cycle();
    check("t7_req_hold", int'(rd_req), 1);
    rd_done = 1'b0;
    rd_ack  = 1'b1;
    next_cycle();
    rd_ack  = 1'b0;
    rd_done = 1'b1;
    empty   = 8'hFF;
    next_cycle();
    rd_done = 1'b0;
    next_cycle();
    check("t7_pulse_count", n_pulse - base, 1);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
